// File: rtl/jpeg_idct_sched.sv
// Block scheduler for the two-pass iDCT: issues coefficient blocks in MCU order,
// bounds blocks in flight and tags each output block with its index.
module jpeg_idct_sched #(
  parameter int MAX_INFLIGHT = 2,
  parameter int RD_BEATS     = 32,
  parameter int OUT_BEATS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ImageInit,
  input  logic [1:0]  SubSampling,
  input  logic [15:0] McuTotal,
  input  logic        BlockReady,
  output logic        BlockRelease,
  input  logic        OutReady,
  output logic        IdctInit,
  output logic        IdctEnable,
  input  logic        IdctRead,
  input  logic        IdctOutEnable,
  output logic [2:0]  OutBlockId,
  output logic        OutMcuLast,
  output logic        OutBlockDone,
  output logic        ImageDone,
  output logic        Error
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int RW = $clog2(RD_BEATS + 1);
  localparam int OW = $clog2(OUT_BEATS + 1);

  typedef enum logic [2:0] {IDLE, INIT, WAIT, ISSUE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      nblk_q, nblk_d;
  logic [15:0]     mcu_total_q, mcu_total_d;
  logic [2:0]      blk_q, blk_d;
  logic [15:0]     mcu_q, mcu_d;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            rel_q, rel_d;
  logic            err_q, err_d;
  logic [3:0]      tag_q [MAX_INFLIGHT];
  logic [3:0]      tag_d [MAX_INFLIGHT];

  logic            fifo_ne, out_beat, pop, push, blk_is_last, issue_last;
  logic [CW-1:0]   wr_idx;

  assign fifo_ne     = (cnt_q != '0);
  assign out_beat    = IdctOutEnable && fifo_ne;
  assign pop         = out_beat && (out_cnt_q == OW'(OUT_BEATS - 1));
  assign blk_is_last = (blk_q == nblk_q - 3'd1);
  assign issue_last  = blk_is_last && (mcu_q == mcu_total_q - 16'd1);
  assign wr_idx      = pop ? cnt_q - CW'(1) : cnt_q;

  always_comb begin
    state_d     = state_q;
    nblk_d      = nblk_q;
    mcu_total_d = mcu_total_q;
    blk_d       = blk_q;
    mcu_d       = mcu_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    rel_d       = 1'b0;
    err_d       = err_q;
    tag_d       = tag_q;
    push        = 1'b0;

    case (state_q)
      IDLE: ;
      INIT: state_d = (mcu_total_q == 16'd0) ? DRAIN : WAIT;
      WAIT: begin
        if (BlockReady && OutReady && (cnt_q < CW'(MAX_INFLIGHT))) begin
          push     = 1'b1;
          last_d   = issue_last;
          rd_cnt_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (IdctRead) begin
          if (rd_cnt_q == RW'(RD_BEATS - 1)) begin
            rd_cnt_d = '0;
            rel_d    = 1'b1;
            if (blk_is_last) begin
              blk_d = 3'd0;
              mcu_d = mcu_q + 16'd1;
            end else begin
              blk_d = blk_q + 3'd1;
            end
            state_d = last_q ? DRAIN : WAIT;
          end else begin
            rd_cnt_d = rd_cnt_q + RW'(1);
          end
        end
      end
      DRAIN: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output side runs regardless of the issue state.
    if (IdctOutEnable && !fifo_ne) err_d = 1'b1;
    if (out_beat) out_cnt_d = pop ? '0 : out_cnt_q + OW'(1);

    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    if (pop) begin
      for (int i = 1; i < MAX_INFLIGHT; i++) tag_d[i-1] = tag_q[i];
    end
    if (push) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        if (CW'(i) == wr_idx) tag_d[i] = {blk_q, issue_last};
      end
    end

    // Image start aborts whatever is in progress.
    if (ImageInit) begin
      state_d = INIT;
      case (SubSampling)
        2'd0:    nblk_d = 3'd1;
        2'd1:    nblk_d = 3'd3;
        2'd2:    nblk_d = 3'd4;
        default: nblk_d = 3'd6;
      endcase
      mcu_total_d = McuTotal;
      blk_d       = 3'd0;
      mcu_d       = 16'd0;
      rd_cnt_d    = '0;
      out_cnt_d   = '0;
      cnt_d       = '0;
      last_d      = 1'b0;
      rel_d       = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      nblk_q      <= 3'd1;
      mcu_total_q <= 16'd0;
      blk_q       <= 3'd0;
      mcu_q       <= 16'd0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      rel_q       <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) tag_q[i] <= 4'd0;
    end else begin
      state_q     <= state_d;
      nblk_q      <= nblk_d;
      mcu_total_q <= mcu_total_d;
      blk_q       <= blk_d;
      mcu_q       <= mcu_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      rel_q       <= rel_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
    end
  end

  assign IdctInit     = (state_q == INIT);
  assign IdctEnable   = (state_q == ISSUE);
  assign BlockRelease = rel_q;
  assign OutBlockId   = fifo_ne ? tag_q[0][3:1] : 3'd0;
  assign OutMcuLast   = fifo_ne & tag_q[0][0];
  assign OutBlockDone = pop;
  assign ImageDone    = (state_q == DRAIN) && (cnt_q == '0);
  assign Error        = err_q;

endmodule

// File: doc/jpeg_idct_sched.md
Name: jpeg_idct_sched

Overview:
- Block scheduler for the two-pass iDCT pipeline.
- Sequences 8x8 coefficient blocks from the dequantizer buffer into the iDCT, one block at a time, in MCU component order.
- Bounds the number of blocks in flight inside the pipeline and tags each output block with its component/block index for the downstream colour buffer.
- Issues the iDCT init pulse at image start and reports image completion.

Parameters:
- MAX_INFLIGHT, 2, maximum blocks issued but not yet fully output (1..3).
- RD_BEATS, 32, IdctRead cycles per block (two coefficients per beat).
- OUT_BEATS, 32, IdctOutEnable cycles per block (two pixels per beat).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ImageInit  in  1  one-cycle pulse, start of image; samples SubSampling and McuTotal.
- SubSampling  in  2  blocks per MCU: 0=gray (1), 1=4:4:4 (3), 2=4:2:2 (4), 3=4:2:0 (6).
- McuTotal  in  16  MCUs in image.
- BlockReady  in  1  coefficient buffer holds a complete block.
- BlockRelease  out  1  one-cycle pulse, coefficient buffer may be reused.
- OutReady  in  1  downstream buffer can accept another block.
- IdctInit  out  1  drives iDCT ProcessInit.
- IdctEnable  out  1  drives iDCT DataInEnable.
- IdctRead  in  1  iDCT DataInRead.
- IdctOutEnable  in  1  iDCT DataOutEnable.
- OutBlockId  out  3  block index (0..5) of the block currently being output.
- OutMcuLast  out  1  current output block is the last block of the image.
- OutBlockDone  out  1  one-cycle pulse, last output beat of a block seen.
- ImageDone  out  1  one-cycle pulse, all blocks of the image output.
- Error  out  1  sticky: IdctOutEnable seen with tag FIFO empty.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and inflight cleared; tag FIFO empty.
- States: IDLE, INIT, WAIT, ISSUE, DRAIN.
- IDLE: wait for ImageInit.
- ImageInit in ANY state: synchronous abort. Clear block, MCU and beat counters, inflight, tag FIFO and Error; capture configuration; next state INIT.
- INIT: IdctInit=1 for exactly one cycle.
  - Next state WAIT, or DRAIN if McuTotal==0 (ImageDone one cycle after INIT, no block issued).
- WAIT: issue when BlockReady && OutReady && inflight<MAX_INFLIGHT.
  - On issue: push tag {blk, last}, inflight+1, state ISSUE.
  - IdctEnable rises in the first ISSUE cycle.
- ISSUE: IdctEnable held 1; count IdctRead cycles.
  - On the RD_BEATS-th read, the next cycle has IdctEnable=0 and BlockRelease=1.
  - Advance blk; at blk==N-1 wrap to 0 and increment the MCU counter.
  - If the block was the last of the image, go to DRAIN, else WAIT.
  - Minimum gap between issues: one cycle.
- Output side, independent of state: count IdctOutEnable beats 0..OUT_BEATS-1.
  - OutBlockId/OutMcuLast show the FIFO head whenever the FIFO is non-empty.
  - On the last beat: OutBlockDone=1 in the same cycle, pop FIFO, inflight-1.
  - Issue and completion in the same cycle: inflight unchanged.
- DRAIN: when inflight==0, ImageDone=1 for one cycle, then IDLE.
- Tag FIFO depth is MAX_INFLIGHT, so overflow cannot occur.
- IdctOutEnable with the FIFO empty sets Error; the beat is ignored and the beat counter does not advance.
- BlockReady/OutReady dropping during ISSUE has no effect; the block completes.
- Counters are 16-bit; McuTotal=65535 must not wrap early.

Test Plan:
- rst low mid-ISSUE -> all outputs 0 immediately (asynchronous); after release, FSM is IDLE and IdctEnable stays 0 until ImageInit.
- ImageInit, SubSampling=3, McuTotal=2, BlockReady/OutReady=1, ideal iDCT model -> one IdctInit pulse; 12 issues; OutBlockId sequence 0,1,2,3,4,5,0..5; OutMcuLast only on the 12th block; 12 BlockRelease and 12 OutBlockDone pulses; one ImageDone.
- MAX_INFLIGHT=2, iDCT latency longer than 2 blocks -> third IdctEnable does not rise until the first OutBlockDone; inflight never exceeds 2.
- OutReady=0 for 100 cycles while BlockReady=1 -> no issue; issue in the cycle after OutReady rises.
- ImageInit asserted during the 5th block of 6 -> FIFO cleared, IdctInit pulse, OutBlockId restarts at 0, no ImageDone from the aborted image.
- McuTotal=0 -> IdctInit then ImageDone on the next cycle, IdctEnable never asserted. A stray IdctOutEnable with no block in flight -> Error=1, held until the next ImageInit.
